warp_table_sched: RTL and testbench

- Sits around the warp table (44-bit warp-entry FIFO with empty/vacant/full flags and write-to-read bypass).
- Write side: round-robin arbitration among NUM_REQ producers (spawn unit, barrier release, pipeline re-queue, …) for the single table write port.
- Read side: drives table pops into a 2-entry skid buffer and presents warps to fetch with a valid/ready handshake, at full throughput under backpressure.

---
 rtl/warp_table_sched.sv | 104 ++++++++++
 tb/tb_warp_table_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_table_sched.sv
// Warp table front/back end: round-robin arbiter onto the table write port and
// a credit-controlled 2-entry skid buffer from table reads to fetch.
module warp_table_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 44,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sched_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wt_write_en,
  output logic [DATA_W-1:0]         wt_write_data,
  input  logic                      wt_fifo_full,
  output logic                      wt_read_en,
  input  logic                      wt_fifo_empty,
  input  logic                      wt_read_valid,
  input  logic [DATA_W-1:0]         wt_read_data,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic [ID_W-1:0]           last_grant,
  output logic                      err_unexp
);

  logic [ID_W-1:0]   rr_ptr, grant_id, idx;
  logic              grant_found, wr_fire;
  logic [1:0]        count;
  logic              inflight, pop, cap;
  logic [2:0]        occ, limit;
  logic [DATA_W-1:0] ent0, ent1;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = rr_ptr + ID_W'(k);
      if (req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign wr_fire       = grant_found && !wt_fifo_full && !rst;
  assign req_ready     = wr_fire ? (NUM_REQ'(1) << grant_id) : '0;
  assign wt_write_en   = wr_fire;
  assign wt_write_data = wr_fire ? req_data[grant_id*DATA_W +: DATA_W] : '0;

  assign out_valid = !rst && (count != 2'd0);
  assign out_data  = rst ? '0 : ent0;
  assign pop       = out_valid && out_ready;
  assign cap       = wt_read_valid && inflight;

  // A read is only issued if its response is guaranteed a skid slot.
  always_comb begin
    occ        = {1'b0, count} + {2'b0, inflight};
    limit      = 3'd2 + {2'b0, pop};
    wt_read_en = !rst && sched_en && !wt_fifo_empty && (occ < limit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      last_grant <= '0;
      count      <= 2'd0;
      inflight   <= 1'b0;
      err_unexp  <= 1'b0;
      ent0       <= '0;
      ent1       <= '0;
    end else begin
      if (wr_fire) begin
        rr_ptr     <= grant_id + ID_W'(1);
        last_grant <= grant_id;
      end
      inflight <= wt_read_en;
      if (wt_read_valid && !inflight) err_unexp <= 1'b1;
      case ({cap, pop})
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) ent0 <= wt_read_data;
          else               ent1 <= wt_read_data;
          count <= count + 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) ent0 <= wt_read_data;
          else begin
            ent0 <= ent1;
            ent1 <= wt_read_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_table_sched.sv
// Directed bench for warp_table_sched; a behavioural warp table supplies the
// empty flag and one-cycle read responses.
module tb_warp_table_sched;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 44;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst, sched_en, wt_fifo_full, out_ready, force_rv;
  logic [NUM_REQ-1:0]        req_valid, req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      wt_write_en, wt_read_en, wt_fifo_empty, wt_read_valid;
  logic [DATA_W-1:0]         wt_write_data, wt_read_data, out_data;
  logic                      out_valid, err_unexp;
  logic [ID_W-1:0]           last_grant;

  logic [DATA_W-1:0] tbl_q[$];
  logic              tm_rvalid;
  logic [DATA_W-1:0] tm_rdata;
  int                tbl_cnt;
  int                checks = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  warp_table_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .sched_en(sched_en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .wt_write_en(wt_write_en), .wt_write_data(wt_write_data),
    .wt_fifo_full(wt_fifo_full), .wt_read_en(wt_read_en),
    .wt_fifo_empty(wt_fifo_empty), .wt_read_valid(wt_read_valid),
    .wt_read_data(wt_read_data), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .last_grant(last_grant), .err_unexp(err_unexp)
  );

  assign wt_fifo_empty = (tbl_cnt == 0);
  assign wt_read_valid = tm_rvalid | force_rv;
  assign wt_read_data  = tm_rdata;

  always @(posedge clk) begin
    if (rst) begin
      tbl_q.delete();
      tm_rvalid <= 1'b0;
      tm_rdata  <= '0;
      tbl_cnt   <= 0;
    end else begin
      tm_rvalid <= 1'b0;
      if (wt_read_en && tbl_q.size() > 0) begin
        tm_rdata  <= tbl_q.pop_front();
        tm_rvalid <= 1'b1;
      end
      if (wt_write_en) tbl_q.push_back(wt_write_data);
      tbl_cnt <= tbl_q.size();
    end
  end

  task automatic idle_inputs();
    req_valid = '0; req_data = '0; sched_en = 1'b0; wt_fifo_full = 1'b0;
    out_ready = 1'b0; force_rv = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1; idle_inputs();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 4'hF; sched_en = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'h0 || wt_write_en !== 1'b0) begin
      failures++; $display("FAIL reset_wr: req_ready=%h wt_write_en=%b want 0", req_ready, wt_write_en); end
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || wt_read_en !== 1'b0) begin
      failures++; $display("FAIL reset_rd: out_valid=%b out_data=%h wt_read_en=%b want 0", out_valid, out_data, wt_read_en); end
    @(negedge clk); rst = 1'b0; idle_inputs(); #1;
    checks++; if (err_unexp !== 1'b0 || last_grant !== 2'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_state: err=%b last_grant=%0d out_valid=%b want 0", err_unexp, last_grant, out_valid); end
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] d;
    d = 44'h0AB_CDEF_1234;
    apply_reset();
    @(negedge clk);
    req_valid = 4'b0010; req_data[1*DATA_W +: DATA_W] = d; sched_en = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (wt_write_en !== 1'b1 || req_ready !== 4'b0010 || wt_write_data !== d || wt_read_en !== 1'b0) begin
      failures++; $display("FAIL single_c0: we=%b rdy=%b wd=%h re=%b want 1 0010 %h 0", wt_write_en, req_ready, wt_write_data, wt_read_en, d); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (wt_read_en !== 1'b1) begin
      failures++; $display("FAIL single_c1: wt_read_en=%b want 1", wt_read_en); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin
      failures++; $display("FAIL single_c2: out_valid=%b want 0", out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== d || last_grant !== 2'd1) begin
      failures++; $display("FAIL single_c3: out_valid=%b out_data=%h last_grant=%0d want 1 %h 1", out_valid, out_data, last_grant, d); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin
      failures++; $display("FAIL single_c4: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_fairness();
    int writes;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [DATA_W-1:0]  exp_d;
    writes = 0;
    apply_reset();
    @(negedge clk);
    req_valid = 4'hF; out_ready = 1'b1; sched_en = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'(44'h100 + i);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_rdy = NUM_REQ'(1) << (k % 4);
      exp_d   = DATA_W'(44'h100 + (k % 4));
      if (wt_write_en === 1'b1) writes++;
      checks++; if (req_ready !== exp_rdy || wt_write_data !== exp_d) begin
        failures++; $display("FAIL fair_%0d: req_ready=%b wd=%h want %b %h", k, req_ready, wt_write_data, exp_rdy, exp_d); end
    end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (writes != 8 || last_grant !== 2'd3) begin
      failures++; $display("FAIL fair_total: writes=%0d last_grant=%0d want 8 3", writes, last_grant); end
  endtask

  task automatic test_full_hold();
    apply_reset();
    @(negedge clk); req_valid = 4'b0001; req_data[0 +: DATA_W] = 44'h5;
    @(negedge clk); req_valid = 4'b1100; wt_fifo_full = 1'b1;
    req_data[2*DATA_W +: DATA_W] = 44'h222; req_data[3*DATA_W +: DATA_W] = 44'h333;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (req_ready !== 4'h0 || wt_write_en !== 1'b0 || last_grant !== 2'd0) begin
        failures++; $display("FAIL full_%0d: req_ready=%b we=%b last_grant=%0d want 0 0 0", k, req_ready, wt_write_en, last_grant); end
    end
    @(negedge clk); wt_fifo_full = 1'b0; #1;
    checks++; if (req_ready !== 4'b0100 || wt_write_data !== 44'h222) begin
      failures++; $display("FAIL full_release: req_ready=%b wd=%h want 0100 222", req_ready, wt_write_data); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (last_grant !== 2'd2) begin
      failures++; $display("FAIL full_last_grant: last_grant=%0d want 2", last_grant); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] d [6];
    int reads;
    reads = 0;
    for (int k = 0; k < 6; k++) d[k] = DATA_W'(44'hA00_0000_0000 + k * 17);
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); req_valid = 4'b0001; req_data[0 +: DATA_W] = d[k]; #1;
      checks++; if (wt_read_en !== 1'b0) begin
        failures++; $display("FAIL bp_preload_%0d: wt_read_en=%b want 0", k, wt_read_en); end
    end
    @(negedge clk); req_valid = '0; sched_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (wt_read_en === 1'b1) reads++;
    end
    checks++; if (reads != 2) begin
      failures++; $display("FAIL bp_reads: reads=%0d want 2", reads); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== d[0] || wt_read_en !== 1'b0) begin
        failures++; $display("FAIL bp_hold_%0d: ov=%b od=%h re=%b want 1 %h 0", k, out_valid, out_data, wt_read_en, d[0]); end
    end
    @(negedge clk); out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== d[k]) begin
        failures++; $display("FAIL bp_drain_%0d: ov=%b od=%h want 1 %h", k, out_valid, out_data, d[k]); end
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_empty: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_unexpected();
    apply_reset();
    @(negedge clk); force_rv = 1'b1;
    @(negedge clk); force_rv = 1'b0; #1;
    checks++; if (err_unexp !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL unexp_set: err=%b out_valid=%b want 1 0", err_unexp, out_valid); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err_unexp !== 1'b1) begin
      failures++; $display("FAIL unexp_sticky: err=%b want 1", err_unexp); end
  endtask

  task automatic test_reset_midop();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); req_valid = 4'b0010; req_data[1*DATA_W +: DATA_W] = DATA_W'(44'h70 + k);
    end
    @(negedge clk); req_valid = '0; sched_en = 1'b1; out_ready = 1'b0;
    @(negedge clk); #1;
    checks++; if (wt_read_en !== 1'b1) begin
      failures++; $display("FAIL midop_read2: wt_read_en=%b want 1", wt_read_en); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 44'h70) begin
      failures++; $display("FAIL midop_pre: ov=%b od=%h want 1 70", out_valid, out_data); end
    rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || wt_read_en !== 1'b0) begin
      failures++; $display("FAIL midop_in_rst: ov=%b re=%b want 0 0", out_valid, wt_read_en); end
    @(negedge clk); rst = 1'b0; sched_en = 1'b0; req_valid = 4'hF; #1;
    checks++; if (out_valid !== 1'b0 || wt_read_en !== 1'b0 || err_unexp !== 1'b0 || last_grant !== 2'd0) begin
      failures++; $display("FAIL midop_after: ov=%b re=%b err=%b lg=%0d want 0 0 0 0", out_valid, wt_read_en, err_unexp, last_grant); end
    checks++; if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL midop_rr_ptr: req_ready=%b want 0001", req_ready); end
    @(negedge clk); req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || err_unexp !== 1'b0) begin
      failures++; $display("FAIL midop_stale: ov=%b err=%b want 0 0", out_valid, err_unexp); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_full_hold();
    test_backpressure();
    test_unexpected();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
